tiny_computer: RTL and testbench

TINY_COMPUTER -- requirements
Module: tiny_computer

---
 rtl/tiny_computer.sv | 211 +++++++++++++++++++++
 tb/tb_tiny_computer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tiny_computer.sv
// tiny_computer: accumulator CPU with a combinational-read, clocked-write RAM.
// Rev 1.0
`default_nettype none

module memory #(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] wdata,
  output logic [data_width-1:0] rdata
);
  logic [data_width-1:0] mem [2**addr_width];

  assign rdata = mem[addr];

  // Contents survive reset; rst only gates a store that races with it.
  always_ff @(posedge clk) begin
    if (write && !rst) mem[addr] <= wdata;
  end
endmodule

module cpu #(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  write,
  output logic [addr_width-1:0] addr,
  output logic [data_width-1:0] wdata,
  input  logic [data_width-1:0] rdata
);
  typedef enum logic [2:0] {
    RESET   = 3'd0,
    FETCH   = 3'd1,
    OPERAND = 3'd2,
    EXEC    = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [data_width-1:0] OP_LDI  = data_width'(8'h00);
  localparam logic [data_width-1:0] OP_LDA  = data_width'(8'h01);
  localparam logic [data_width-1:0] OP_STA  = data_width'(8'h02);
  localparam logic [data_width-1:0] OP_HALT = data_width'(8'h03);
  localparam logic [data_width-1:0] OP_JMPA = data_width'(8'h04);
  localparam logic [data_width-1:0] OP_CLR  = data_width'(8'h05);
  localparam logic [data_width-1:0] OP_ADD  = data_width'(8'h06);
  localparam logic [data_width-1:0] OP_SUB  = data_width'(8'h07);
  localparam logic [data_width-1:0] OP_JMP  = data_width'(8'h08);
  localparam logic [data_width-1:0] OP_JZ   = data_width'(8'h09);

  state_t                state, state_d;
  logic [addr_width-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [data_width-1:0] a_q, a_d, ir_q, ir_d, wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [addr_width-1:0] opnd_addr, a_addr, pc_plus1, pc_plus2;

  // Data-to-address conversion: truncate or zero-extend depending on widths.
  if (addr_width <= data_width) begin : g_addr_trunc
    assign opnd_addr = rdata[addr_width-1:0];
    assign a_addr    = a_q[addr_width-1:0];
  end else begin : g_addr_zext
    assign opnd_addr = {{(addr_width-data_width){1'b0}}, rdata};
    assign a_addr    = {{(addr_width-data_width){1'b0}}, a_q};
  end

  assign pc_plus1 = pc_q + addr_width'(1);
  assign pc_plus2 = pc_q + addr_width'(2);

  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign write = write_q;

  always_comb begin
    state_d = state;
    pc_d    = pc_q;
    addr_d  = addr_q;
    a_d     = a_q;
    ir_d    = ir_q;
    wdata_d = wdata_q;
    write_d = 1'b0;
    case (state)
      RESET: begin
        state_d = FETCH;
        pc_d    = '0;
        addr_d  = '0;
      end
      // addr already equals PC on entry to FETCH.
      FETCH: begin
        ir_d = rdata;
        case (rdata)
          OP_HALT: state_d = HALT;
          OP_JMPA: begin
            pc_d   = a_addr;
            addr_d = a_addr;
          end
          OP_CLR: begin
            a_d    = '0;
            pc_d   = pc_plus1;
            addr_d = pc_plus1;
          end
          default: begin
            state_d = OPERAND;
            addr_d  = pc_plus1;
          end
        endcase
      end
      OPERAND: begin
        state_d = FETCH;
        pc_d    = pc_plus2;
        addr_d  = pc_plus2;
        case (ir_q)
          OP_LDI: a_d = rdata;
          OP_LDA, OP_ADD, OP_SUB: begin
            state_d = EXEC;
            pc_d    = pc_q;
            addr_d  = opnd_addr;
          end
          OP_STA: begin
            state_d = EXEC;
            pc_d    = pc_q;
            addr_d  = opnd_addr;
            wdata_d = a_q;
            write_d = 1'b1;
          end
          OP_JMP: begin
            pc_d   = opnd_addr;
            addr_d = opnd_addr;
          end
          OP_JZ: begin
            if (a_q == '0) begin
              pc_d   = opnd_addr;
              addr_d = opnd_addr;
            end
          end
          default: ;
        endcase
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_plus2;
        addr_d  = pc_plus2;
        case (ir_q)
          OP_LDA:  a_d = rdata;
          OP_ADD:  a_d = a_q + rdata;
          OP_SUB:  a_d = a_q - rdata;
          default: ;
        endcase
      end
      HALT:    ;
      default: state_d = RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RESET;
      pc_q    <= '0;
      addr_q  <= '0;
      a_q     <= '0;
      ir_q    <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state   <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      a_q     <= a_d;
      ir_q    <= ir_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end
endmodule

module tiny_computer #(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input logic clk,
  input logic rst
);
  logic                  write;
  logic [addr_width-1:0] addr;
  logic [data_width-1:0] wdata;
  logic [data_width-1:0] rdata;

  cpu #(.addr_width(addr_width), .data_width(data_width)) u_cpu (
    .clk  (clk),
    .rst  (rst),
    .write(write),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata)
  );

  memory #(.addr_width(addr_width), .data_width(data_width)) u_memory (
    .clk  (clk),
    .rst  (rst),
    .write(write),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata)
  );
endmodule

`default_nettype wire

// File: tb/tb_tiny_computer.sv
// tb_tiny_computer: directed programs with hand-computed results.
// Rev 1.0
`default_nettype none

module tb_tiny_computer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  tiny_computer #(.addr_width(8), .data_width(8)) dut (
    .clk(clk),
    .rst(rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    dut.u_memory.mem[a] = d;
  endtask

  // Assert reset and fill memory with HALT so any runaway stops.
  task automatic begin_test();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) dut.u_memory.mem[i] = 8'h03;
  endtask

  // Two-cycle reset pulse, released on a falling edge.
  task automatic go();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int cycles);
    logic [2:0] p_state;
    logic [7:0] p_addr, p_opc, nxt;
    logic       p_write;
    p_state = dut.u_cpu.state;
    p_addr  = dut.u_cpu.addr;
    p_opc   = dut.u_cpu.rdata;
    p_write = dut.u_cpu.write;
    cycles  = 0;
    while (dut.u_cpu.state != 3'd4 && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (p_state == 3'd1 && !p_write && (p_opc < 8'h03 || p_opc > 8'h05)) begin
        nxt = p_addr + 8'd1;
        check("fetch_inc", 32'(dut.u_cpu.addr), 32'(nxt));
      end
      if (dut.u_cpu.write) check("write_in_exec", 32'(dut.u_cpu.state), 32'd3);
      p_state = dut.u_cpu.state;
      p_addr  = dut.u_cpu.addr;
      p_opc   = dut.u_cpu.rdata;
      p_write = dut.u_cpu.write;
    end
    check("halt_reached", 32'(dut.u_cpu.state), 32'd4);
  endtask

  initial begin
    int cyc;

    // LDI 5; ADD [10]; STA [11]; HALT
    begin_test();
    poke(8'h00, 8'h00); poke(8'h01, 8'h05); poke(8'h02, 8'h06); poke(8'h03, 8'h10);
    poke(8'h04, 8'h02); poke(8'h05, 8'h11); poke(8'h06, 8'h03); poke(8'h10, 8'h03);
    @(negedge clk);
    check("rst_state", 32'(dut.u_cpu.state), 32'd0);
    check("rst_pc",    32'(dut.u_cpu.pc_q),  32'd0);
    check("rst_a",     32'(dut.u_cpu.a_q),   32'd0);
    check("rst_ir",    32'(dut.u_cpu.ir_q),  32'd0);
    check("rst_addr",  32'(dut.u_cpu.addr),  32'd0);
    check("rst_wdata", 32'(dut.u_cpu.wdata), 32'd0);
    check("rst_write", 32'(dut.u_cpu.write), 32'd0);
    rst = 1'b0;
    run_to_halt(40, cyc);
    check("halt_within_12", 32'(cyc <= 12), 32'd1);
    check("prog1_a",    32'(dut.u_cpu.a_q),           32'h08);
    check("prog1_m11",  32'(dut.u_memory.mem[8'h11]), 32'h08);
    check("prog1_addr", 32'(dut.u_cpu.addr),          32'h06);
    repeat (3) @(negedge clk);
    check("halt_hold_addr",  32'(dut.u_cpu.addr),  32'h06);
    check("halt_hold_state", 32'(dut.u_cpu.state), 32'd4);
    check("halt_hold_write", 32'(dut.u_cpu.write), 32'd0);
    check("halt_hold_a",     32'(dut.u_cpu.a_q),   32'h08);

    // JMP F0; HALT at F0
    begin_test();
    poke(8'h00, 8'h08); poke(8'h01, 8'hF0);
    go();
    @(negedge clk);
    check("jmp_first_fetch", 32'(dut.u_cpu.state), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("jmp_addr",  32'(dut.u_cpu.addr),  32'hF0);
    check("jmp_state", 32'(dut.u_cpu.state), 32'd1);
    run_to_halt(10, cyc);
    check("jmp_halt_addr", 32'(dut.u_cpu.addr), 32'hF0);

    // JZ 20 with A=0 -> taken
    begin_test();
    poke(8'h00, 8'h09); poke(8'h01, 8'h20);
    go();
    run_to_halt(20, cyc);
    check("jz_taken_pc", 32'(dut.u_cpu.pc_q), 32'h20);

    // LDI 1; JZ 20 -> falls through to HALT at 4
    begin_test();
    poke(8'h00, 8'h00); poke(8'h01, 8'h01); poke(8'h02, 8'h09); poke(8'h03, 8'h20);
    poke(8'h20, 8'h00); poke(8'h21, 8'h77);
    go();
    run_to_halt(20, cyc);
    check("jz_fall_pc", 32'(dut.u_cpu.pc_q), 32'h04);
    check("jz_fall_a",  32'(dut.u_cpu.a_q),  32'h01);

    // LDI FF; ADD [40]=2 -> 01; STA [41]; LDI 30; JMPA; at 30: CLR; HALT
    begin_test();
    poke(8'h00, 8'h00); poke(8'h01, 8'hFF); poke(8'h02, 8'h06); poke(8'h03, 8'h40);
    poke(8'h04, 8'h02); poke(8'h05, 8'h41); poke(8'h06, 8'h00); poke(8'h07, 8'h30);
    poke(8'h08, 8'h04); poke(8'h40, 8'h02); poke(8'h41, 8'h00);
    poke(8'h30, 8'h05); poke(8'h31, 8'h03);
    go();
    run_to_halt(40, cyc);
    check("add_wrap_m41", 32'(dut.u_memory.mem[8'h41]), 32'h01);
    check("clr_a",        32'(dut.u_cpu.a_q),           32'h00);
    check("jmpa_clr_addr",32'(dut.u_cpu.addr),          32'h31);

    // NOP; LDA [50]=10; SUB [51]=20 -> F0; STA [52]; HALT
    begin_test();
    poke(8'h00, 8'h0A); poke(8'h01, 8'h77); poke(8'h02, 8'h01); poke(8'h03, 8'h50);
    poke(8'h04, 8'h07); poke(8'h05, 8'h51); poke(8'h06, 8'h02); poke(8'h07, 8'h52);
    poke(8'h50, 8'h10); poke(8'h51, 8'h20); poke(8'h52, 8'h00);
    go();
    run_to_halt(40, cyc);
    check("sub_a",    32'(dut.u_cpu.a_q),           32'hF0);
    check("sub_m52",  32'(dut.u_memory.mem[8'h52]), 32'hF0);
    check("nop_addr", 32'(dut.u_cpu.addr),          32'h08);

    // LDI AA; STA [60]; HALT -- reset lands in STA EXEC
    begin_test();
    poke(8'h00, 8'h00); poke(8'h01, 8'hAA); poke(8'h02, 8'h02); poke(8'h03, 8'h60);
    poke(8'h60, 8'h55);
    go();
    cyc = 0;
    while (!dut.u_cpu.write && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("sta_exec_seen", 32'(dut.u_cpu.write), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_state", 32'(dut.u_cpu.state), 32'd0);
    check("abort_write", 32'(dut.u_cpu.write), 32'd0);
    check("abort_addr",  32'(dut.u_cpu.addr),  32'd0);
    @(posedge clk);
    #1;
    check("abort_m60", 32'(dut.u_memory.mem[8'h60]), 32'h55);
    go();
    run_to_halt(20, cyc);
    check("restart_m60",  32'(dut.u_memory.mem[8'h60]), 32'hAA);
    check("restart_addr", 32'(dut.u_cpu.addr),          32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire
